post_trigger_counter: RTL

Loadable down-counter that measures out the post-trigger capture window of the oscilloscope acquisition path. On a trigger (`start`) it latches a sample count and a prescale divider. It then counts down one step per prescaled sample tick while `enable` is high, and emits a one-cycle `done` pulse when the count reaches zero. It sits between the trigger detector and the capture-buffer write controller, which uses `tick` as its write strobe and `done` to stop writing.

---
 rtl/oscilo_pkg.sv | 11 +
 rtl/tick_prescaler.sv | 46 ++++
 rtl/post_trigger_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/oscilo_pkg.sv
// Shared types and default widths for the acquisition path.
// Used by the post-trigger capture window counter.
package oscilo_pkg;
  localparam int PT_WIDTH          = 16;
  localparam int PT_PRESCALE_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pt_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Sample-rate divider: one terminal cycle every prescale+1 enabled cycles.
// The divider value is shadowed on load so input changes mid-run are ignored.
module tick_prescaler
  import oscilo_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PT_PRESCALE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      terminal
);

  logic [PRESCALE_WIDTH-1:0] shadow_q, shadow_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign terminal = (cnt_q == shadow_q);

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      load: begin
        shadow_d = prescale;
        cnt_d    = '0;
      end
      enable: begin
        cnt_d = terminal ? '0 : cnt_q + PRESCALE_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/post_trigger_counter.sv
// Post-trigger capture window: counts prescaled sample ticks after a trigger
// and pulses done when the requested number of ticks has been emitted.
module post_trigger_counter
  import oscilo_pkg::*;
#(
  parameter int WIDTH          = PT_WIDTH,
  parameter int PRESCALE_WIDTH = PT_PRESCALE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIDTH-1:0]          length,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          count_out,
  output logic                      busy,
  output logic                      tick,
  output logic                      done
);

  pt_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             pre_load, pre_en, terminal;

  tick_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .load    (pre_load),
    .enable  (pre_en),
    .prescale(prescale),
    .terminal(terminal)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    pre_load = 1'b0;
    pre_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length != '0) begin
            pre_load = 1'b1;
            count_d  = length;
            busy_d   = 1'b1;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (enable) begin
          pre_en = 1'b1;
          if (terminal && count_q != '0) begin
            tick_d  = 1'b1;
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign done      = done_q;

endmodule
